sequence_loader: RTL and testbench

SEQUENCE_LOADER -- requirements
Module: sequence_loader

---
 rtl/sequence_loader.sv | 184 ++++++++++++++++++
 tb/tb_sequence_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_loader.sv
// Sequence loader: buffers a haplotype and a read (with per-base priors) from the host,
// serves single-cycle fetches to the PE array, and hands the array's final result back.
module sequence_loader #(
    parameter  int MAX_STRING_LENGTH = 64,
    parameter  int NUM_PROCS         = 4,
    parameter  int BASE_W            = 3,
    localparam int LEN_W             = $clog2(MAX_STRING_LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_sel,
    input  logic [BASE_W-1:0] load_base,
    input  logic [63:0]       load_match,
    input  logic [63:0]       load_neq,
    input  logic              load_last,
    output logic              arr_reset,
    output logic [LEN_W-1:0]  string_length,
    output logic [LEN_W-1:0]  y_length,
    input  logic              read_x_valid,
    input  logic [LEN_W-1:0]  read_index_x,
    input  logic              read_y_valid,
    input  logic [LEN_W-1:0]  read_index_y,
    output logic [BASE_W-1:0] ref_base,
    output logic [BASE_W-1:0] exp_base,
    output logic              base_valid,
    output logic [63:0]       prior_match,
    output logic [63:0]       prior_neq,
    output logic              prior_valid,
    input  logic              arr_complete,
    input  logic [63:0]       arr_final_val,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [63:0]       result_val,
    output logic              len_err
);

    localparam int               DEPTH    = 1 << LEN_W;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH - 2);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(NUM_PROCS);

    localparam logic [1:0] LOAD_HAP  = 2'd0;
    localparam logic [1:0] LOAD_READ = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] DRAIN     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  string_length_q, string_length_d;
    logic [LEN_W-1:0]  y_length_q, y_length_d;
    logic              len_err_q, len_err_d;
    logic              arr_reset_q;

    logic [BASE_W-1:0] ref_base_q, exp_base_q;
    logic [63:0]       prior_match_q, prior_neq_q;
    logic              base_valid_q, prior_valid_q;
    logic [63:0]       result_val_q;

    logic [BASE_W-1:0] hap_mem       [DEPTH];
    logic [BASE_W-1:0] read_base_mem [DEPTH];
    logic [63:0]       match_mem     [DEPTH];
    logic [63:0]       neq_mem       [DEPTH];

    logic             beat, hap_store, read_store, store;
    logic             at_limit, seg_end, seg_short, in_run;
    logic [LEN_W-1:0] seg_len;

    assign load_ready = (state_q == LOAD_HAP) || (state_q == LOAD_READ);
    assign in_run     = (state_q == RUN);
    assign beat       = load_valid & load_ready;
    assign hap_store  = beat & (state_q == LOAD_HAP)  & ~load_sel;
    assign read_store = beat & (state_q == LOAD_READ) &  load_sel;
    assign store      = hap_store | read_store;
    assign at_limit   = (wr_ptr_q == LAST_IDX);
    assign seg_end    = store & (load_last | at_limit);
    assign seg_len    = wr_ptr_q + 1'b1;
    assign seg_short  = (seg_len < MIN_LEN);

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        string_length_d = string_length_q;
        y_length_d      = y_length_q;
        len_err_d       = len_err_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            LOAD_HAP, LOAD_READ: begin
                if (seg_end) begin
                    wr_ptr_d = '0;
                    if (state_q == LOAD_HAP) string_length_d = seg_len;
                    else                     y_length_d      = seg_len;
                    // A short segment is dropped and reloaded in the same state.
                    if (!seg_short) begin
                        state_d = (state_q == LOAD_HAP) ? LOAD_READ : RUN;
                        if (state_q == LOAD_READ) len_err_d = 1'b0;
                    end
                    if (seg_short || at_limit) len_err_d = 1'b1;
                end
            end
            RUN:     if (arr_complete) state_d = DRAIN;
            DRAIN:   if (result_ready) state_d = LOAD_HAP;
            default: state_d = LOAD_HAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= LOAD_HAP;
            wr_ptr_q        <= '0;
            string_length_q <= '0;
            y_length_q      <= '0;
            len_err_q       <= 1'b0;
            arr_reset_q     <= 1'b1;
            ref_base_q      <= '0;
            exp_base_q      <= '0;
            prior_match_q   <= '0;
            prior_neq_q     <= '0;
            base_valid_q    <= 1'b0;
            prior_valid_q   <= 1'b0;
            result_val_q    <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            string_length_q <= string_length_d;
            y_length_q      <= y_length_d;
            len_err_q       <= len_err_d;
            arr_reset_q     <= (state_d != RUN);
            base_valid_q    <= in_run & read_x_valid;
            prior_valid_q   <= in_run & read_y_valid;

            if (in_run && read_x_valid) begin
                ref_base_q <= (read_index_x < string_length_q) ? hap_mem[read_index_x] : '0;
            end
            // Out-of-range fetches return zeros but are still flagged valid.
            if (in_run && read_y_valid) begin
                if (read_index_y < y_length_q) begin
                    exp_base_q    <= read_base_mem[read_index_y];
                    prior_match_q <= match_mem[read_index_y];
                    prior_neq_q   <= neq_mem[read_index_y];
                end else begin
                    exp_base_q    <= '0;
                    prior_match_q <= '0;
                    prior_neq_q   <= '0;
                end
            end

            if (in_run && arr_complete) begin
                result_val_q <= arr_final_val;
            end
        end
    end

    // NOTE: storage arrays are deliberately left unreset; lengths gate every read.
    always_ff @(posedge clk) begin
        if (hap_store) begin
            hap_mem[wr_ptr_q] <= load_base;
        end
        if (read_store) begin
            read_base_mem[wr_ptr_q] <= load_base;
            match_mem[wr_ptr_q]     <= load_match;
            neq_mem[wr_ptr_q]       <= load_neq;
        end
    end

    assign arr_reset     = arr_reset_q;
    assign string_length = string_length_q;
    assign y_length      = y_length_q;
    assign ref_base      = ref_base_q;
    assign exp_base      = exp_base_q;
    assign base_valid    = base_valid_q;
    assign prior_match   = prior_match_q;
    assign prior_neq     = prior_neq_q;
    assign prior_valid   = prior_valid_q;
    assign result_valid  = (state_q == DRAIN);
    assign result_val    = result_val_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_sequence_loader.sv
// Directed bench for sequence_loader: load, fetch, result handshake, length errors, reset abort.
module tb_sequence_loader;

    localparam int LEN_W = 6;

    localparam logic [1:0] S_LOAD_HAP  = 2'd0;
    localparam logic [1:0] S_LOAD_READ = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_DRAIN     = 2'd3;

    localparam logic [2:0] A = 3'd1;
    localparam logic [2:0] C = 3'd2;
    localparam logic [2:0] G = 3'd3;
    localparam logic [2:0] T = 3'd4;

    localparam logic [63:0] M0 = 64'h3FEF_0000_0000_0000;
    localparam logic [63:0] N0 = 64'h3F1A_0000_0000_0000;
    localparam logic [63:0] FV = 64'h3E00_0000_0000_0001;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid, load_ready, load_sel, load_last;
    logic [2:0]       load_base;
    logic [63:0]      load_match, load_neq;
    logic             arr_reset;
    logic [LEN_W-1:0] string_length, y_length;
    logic             read_x_valid, read_y_valid;
    logic [LEN_W-1:0] read_index_x, read_index_y;
    logic [2:0]       ref_base, exp_base;
    logic             base_valid, prior_valid;
    logic [63:0]      prior_match, prior_neq;
    logic             arr_complete;
    logic [63:0]      arr_final_val;
    logic             result_valid, result_ready;
    logic [63:0]      result_val;
    logic             len_err;

    int n_checks = 0;
    int n_fail   = 0;

    sequence_loader dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
        .load_base(load_base), .load_match(load_match), .load_neq(load_neq),
        .load_last(load_last), .arr_reset(arr_reset),
        .string_length(string_length), .y_length(y_length),
        .read_x_valid(read_x_valid), .read_index_x(read_index_x),
        .read_y_valid(read_y_valid), .read_index_y(read_index_y),
        .ref_base(ref_base), .exp_base(exp_base), .base_valid(base_valid),
        .prior_match(prior_match), .prior_neq(prior_neq), .prior_valid(prior_valid),
        .arr_complete(arr_complete), .arr_final_val(arr_final_val),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_val(result_val), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic sel, input logic [2:0] base,
                             input logic [63:0] m, input logic [63:0] n, input logic last);
        load_valid = 1'b1;
        load_sel   = sel;
        load_base  = base;
        load_match = m;
        load_neq   = n;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic xv, input logic [LEN_W-1:0] xi,
                         input logic yv, input logic [LEN_W-1:0] yi);
        read_x_valid = xv;
        read_index_x = xi;
        read_y_valid = yv;
        read_index_y = yi;
        tick();
        read_x_valid = 1'b0;
        read_y_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        load_valid = 1'b0; load_sel = 1'b0; load_last = 1'b0;
        load_base = '0; load_match = '0; load_neq = '0;
        read_x_valid = 1'b0; read_y_valid = 1'b0;
        read_index_x = '0; read_index_y = '0;
        arr_complete = 1'b0; arr_final_val = '0; result_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_load_ready",   load_ready,    1);
        check("rst_arr_reset",    arr_reset,     1);
        check("rst_string_len",   string_length, 0);
        check("rst_y_len",        y_length,      0);
        check("rst_valids",       {base_valid, prior_valid, result_valid}, 0);
        check("rst_result_val",   result_val,    0);
        check("rst_len_err",      len_err,       0);
        check("rst_state",        dut.state_q,   S_LOAD_HAP);

        // Too-short haplotype is rejected and the loader waits for another one.
        send_beat(0, A, 0, 0, 0);
        send_beat(0, C, 0, 0, 0);
        send_beat(0, G, 0, 0, 1);
        check("short_len_err",    len_err,       1);
        check("short_state",      dut.state_q,   S_LOAD_HAP);
        check("short_load_ready", load_ready,    1);

        // Five-base haplotype with a stray read beat that must be dropped.
        send_beat(0, A, 0, 0, 0);
        send_beat(0, C, 0, 0, 0);
        send_beat(1, T, 64'h1, 64'h2, 1);
        send_beat(0, G, 0, 0, 0);
        send_beat(0, T, 0, 0, 0);
        send_beat(0, A, 0, 0, 1);
        check("hap_state",        dut.state_q,   S_LOAD_READ);
        check("hap_string_len",   string_length, 5);
        check("hap_len_err_kept", len_err,       1);

        // Read with a stray haplotype beat that must be dropped.
        send_beat(1, A, M0 + 0, N0 + 0, 0);
        send_beat(1, C, M0 + 1, N0 + 1, 0);
        send_beat(0, T, 0, 0, 1);
        send_beat(1, G, M0 + 2, N0 + 2, 0);
        check("read_arr_reset_hi", arr_reset,    1);
        send_beat(1, T, M0 + 3, N0 + 3, 1);
        check("run_arr_reset_lo", arr_reset,     0);
        check("run_state",        dut.state_q,   S_RUN);
        check("run_y_len",        y_length,      4);
        check("run_len_err_clr",  len_err,       0);
        check("run_load_ready",   load_ready,    0);

        // Independent x/y fetch in the same cycle, then idle.
        fetch(1, 2, 1, 3);
        check("fx_ref_base",      ref_base,      G);
        check("fx_exp_base",      exp_base,      T);
        check("fx_base_valid",    base_valid,    1);
        check("fx_prior_valid",   prior_valid,   1);
        check("fx_prior_match",   prior_match,   M0 + 3);
        check("fx_prior_neq",     prior_neq,     N0 + 3);
        tick();
        check("idle_valids",      {base_valid, prior_valid}, 0);
        check("idle_ref_held",    ref_base,      G);
        check("idle_exp_held",    exp_base,      T);

        fetch(1, 4, 1, 0);
        check("f2_ref_base",      ref_base,      A);
        check("f2_exp_base",      exp_base,      A);
        check("f2_prior_match",   prior_match,   M0);
        check("f2_prior_neq",     prior_neq,     N0);

        // Out-of-range fetches on both ports.
        fetch(1, 5, 1, 7);
        check("oor_ref_base",     ref_base,      0);
        check("oor_base_valid",   base_valid,    1);
        check("oor_exp_base",     exp_base,      0);
        check("oor_priors",       {prior_match, prior_neq}, 0);
        check("oor_prior_valid",  prior_valid,   1);
        check("oor_len_err",      len_err,       0);

        // Result capture while arr_complete stays high; result held until accepted.
        arr_complete  = 1'b1;
        arr_final_val = FV;
        tick();
        check("drain_state",      dut.state_q,   S_DRAIN);
        check("drain_res_valid",  result_valid,  1);
        check("drain_res_val",    result_val,    FV);
        arr_final_val = 64'h1234_5678_9ABC_DEF0;
        read_x_valid  = 1'b1;
        read_y_valid  = 1'b1;
        tick();
        check("drain_no_fetch",   {base_valid, prior_valid}, 0);
        read_x_valid  = 1'b0;
        read_y_valid  = 1'b0;
        tick();
        arr_complete  = 1'b0;
        check("drain_hold_val",   result_val,    FV);
        tick();
        check("drain_hold_valid", result_valid,  1);
        check("drain_hold_val2",  result_val,    FV);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("done_state",       dut.state_q,   S_LOAD_HAP);
        check("done_arr_reset",   arr_reset,     1);
        check("done_res_valid",   result_valid,  0);
        check("done_load_ready",  load_ready,    1);

        // Second job at the minimum legal length overwrites from index 0.
        send_beat(0, T, 0, 0, 0);
        send_beat(0, T, 0, 0, 0);
        send_beat(0, G, 0, 0, 0);
        send_beat(0, C, 0, 0, 1);
        check("j2_string_len",    string_length, 4);
        for (int i = 0; i < 4; i++) begin
            send_beat(1, G, M0 + 64'(i + 8), N0 + 64'(i + 8), (i == 3));
        end
        check("j2_state",         dut.state_q,   S_RUN);
        fetch(1, 3, 1, 1);
        check("j2_ref_base",      ref_base,      C);
        check("j2_exp_base",      exp_base,      G);
        check("j2_prior_match",   prior_match,   M0 + 9);

        // Reset in the middle of RUN aborts the job.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state",      dut.state_q,   S_LOAD_HAP);
        check("abort_arr_reset",  arr_reset,     1);
        check("abort_lengths",    {string_length, y_length}, 0);
        check("abort_res_valid",  result_valid,  0);

        // Haplotype with no last flag ends on the highest storable index.
        for (int i = 0; i < 63; i++) begin
            send_beat(0, G, 0, 0, 0);
        end
        check("ovf_len_err",      len_err,       1);
        check("ovf_string_len",   string_length, 63);
        check("ovf_state",        dut.state_q,   S_LOAD_READ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
